// File: rtl/key_chunk_tx_if.sv
// rtl/key_chunk_tx_if.sv - start/abort/key request and chunked key strobe bundle for key_chunk_tx
interface key_chunk_tx_if #(
  parameter int KEY_WIDTH = 32,
  parameter int CHUNK     = 4
);
  localparam int N  = KEY_WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic                 start;
  logic                 abort;
  logic [KEY_WIDTH-1:0] key_in;
  logic                 load_key;
  logic [CHUNK-1:0]     key_data;
  logic                 busy;
  logic                 done;
  logic [IW-1:0]        chunk_idx;

  modport master (
    output start, abort, key_in,
    input  load_key, key_data, busy, done, chunk_idx
  );

  modport slave (
    input  start, abort, key_in,
    output load_key, key_data, busy, done, chunk_idx
  );
endinterface

// File: rtl/key_chunk_tx.sv
// rtl/key_chunk_tx.sv - sends a captured key MSB-first as CHUNK-bit strobes with optional inter-chunk gap
module key_chunk_tx #(
  parameter int KEY_WIDTH = 32,
  parameter int CHUNK     = 4,
  parameter int GAP       = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  key_chunk_tx_if.slave bus
);
  localparam int N  = KEY_WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  logic [1:0]           state_q, state_d;
  logic [KEY_WIDTH-1:0] shreg_q, shreg_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [IW-1:0]        chunk_idx_q, chunk_idx_d;
  logic                 load_key_q, load_key_d;
  logic [CHUNK-1:0]     key_data_q, key_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 advance;

  // shreg holds only the chunks not yet strobed, so the next chunk is always its top CHUNK bits
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    gap_cnt_d   = gap_cnt_q;
    chunk_idx_d = chunk_idx_q;
    load_key_d  = 1'b0;
    key_data_d  = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    advance     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d     = S_SEND;
          load_key_d  = 1'b1;
          key_data_d  = bus.key_in[KEY_WIDTH-1 -: CHUNK];
          shreg_d     = bus.key_in << CHUNK;
          chunk_idx_d = '0;
          busy_d      = 1'b1;
        end
      end
      S_SEND: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (chunk_idx_q == LAST_IDX) begin
          state_d = S_DONE;
          busy_d  = 1'b1;
          done_d  = 1'b1;
        end else if (GAP > 0) begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_LOAD;
          busy_d    = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == GAP_ONE) begin
          advance = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
          busy_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (advance) begin
      state_d     = S_SEND;
      load_key_d  = 1'b1;
      key_data_d  = shreg_q[KEY_WIDTH-1 -: CHUNK];
      shreg_d     = shreg_q << CHUNK;
      chunk_idx_d = chunk_idx_q + IW'(1);
      busy_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      gap_cnt_q   <= '0;
      chunk_idx_q <= '0;
      load_key_q  <= 1'b0;
      key_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      gap_cnt_q   <= gap_cnt_d;
      chunk_idx_q <= chunk_idx_d;
      load_key_q  <= load_key_d;
      key_data_q  <= key_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.load_key  = load_key_q;
  assign bus.key_data  = key_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.chunk_idx = chunk_idx_q;
endmodule

// File: tb/tb_key_chunk_tx.sv
// tb/tb_key_chunk_tx.sv - bench for key_chunk_tx across GAP values 2, 0, 1 and 3
module tb_key_chunk_tx;
  localparam int KW = 32;
  localparam int CW = 4;
  localparam int N  = KW / CW;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_s [NI];
  logic          abort_s [NI];
  logic [KW-1:0] key_s   [NI];
  logic          ld_o    [NI];
  logic [CW-1:0] kd_o    [NI];
  logic          busy_o  [NI];
  logic          done_o  [NI];
  logic [2:0]    idx_o   [NI];

  function automatic int gap_of(int i);
    case (i)
      0: return 2;
      1: return 0;
      2: return 1;
      default: return 3;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : u
    key_chunk_tx_if #(.KEY_WIDTH(KW), .CHUNK(CW)) bus ();
    assign bus.start  = start_s[g];
    assign bus.abort  = abort_s[g];
    assign bus.key_in = key_s[g];
    assign ld_o[g]    = bus.load_key;
    assign kd_o[g]    = bus.key_data;
    assign busy_o[g]  = bus.busy;
    assign done_o[g]  = bus.done;
    assign idx_o[g]   = bus.chunk_idx;

    key_chunk_tx #(.KEY_WIDTH(KW), .CHUNK(CW), .GAP(gap_of(g))) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  int vectors;
  int miscompares;

  // model: a transfer is just "relative cycle since acceptance" plus the captured key
  bit            m_act [NI];
  int            m_rel [NI];
  int            m_idx [NI];
  logic [KW-1:0] m_key [NI];
  logic [KW-1:0] rx    [NI];
  int            n_done[NI];

  logic [CW-1:0] s1_nib [N] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};
  logic [CW-1:0] s2_nib [N] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge(input int i);
    int gp   = gap_of(i);
    int last = 1 + (N - 1) * (gp + 1);
    if (!rst_n) begin
      m_act[i] = 1'b0;
      m_idx[i] = 0;
    end else if (m_act[i]) begin
      if (abort_s[i]) begin
        m_act[i] = 1'b0;
      end else begin
        m_rel[i]++;
        if (m_rel[i] > last + 1) m_act[i] = 1'b0;
        else if (m_rel[i] <= last && (m_rel[i] - 1) % (gp + 1) == 0) m_idx[i] = (m_rel[i] - 1) / (gp + 1);
      end
    end else if (start_s[i] && !abort_s[i]) begin
      m_act[i] = 1'b1;
      m_rel[i] = 1;
      m_idx[i] = 0;
      m_key[i] = key_s[i];
      rx[i]    = '0;
    end
  endtask

  task automatic compare(input int i);
    int            gp     = gap_of(i);
    int            last   = 1 + (N - 1) * (gp + 1);
    bit            strobe = m_act[i] && m_rel[i] <= last && (m_rel[i] - 1) % (gp + 1) == 0;
    logic [CW-1:0] ed     = '0;
    if (strobe) ed = m_key[i][KW-1-((m_rel[i]-1)/(gp+1))*CW -: CW];
    chk($sformatf("u%0d.load_key", i), 64'(ld_o[i]), 64'(strobe));
    chk($sformatf("u%0d.key_data", i), 64'(kd_o[i]), 64'(ed));
    chk($sformatf("u%0d.busy", i), 64'(busy_o[i]), 64'(m_act[i]));
    chk($sformatf("u%0d.done", i), 64'(done_o[i]), 64'(m_act[i] && m_rel[i] == last + 1));
    chk($sformatf("u%0d.chunk_idx", i), 64'(idx_o[i]), 64'(m_idx[i]));
    if (ld_o[i] === 1'b1) rx[i] = {rx[i][KW-CW-1:0], kd_o[i]};
    if (done_o[i] === 1'b1) begin
      n_done[i]++;
      chk($sformatf("u%0d.loopback", i), 64'(rx[i]), 64'(m_key[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_edge(i);
    #1;
    for (int i = 0; i < NI; i++) compare(i);
  endtask

  function automatic bit any_busy();
    bit b = 1'b0;
    for (int i = 0; i < NI; i++) if (busy_o[i] !== 1'b0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle(input string name);
    for (int w = 0; w < 60; w++) begin
      if (!any_busy()) break;
      step();
    end
    chk(name, 64'(any_busy()), 64'(0));
  endtask

  int d0, d1;
  int dd[NI];

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; key_s[i] = '0;
      m_act[i] = 1'b0; m_rel[i] = 0; m_idx[i] = 0; m_key[i] = '0; rx[i] = '0; n_done[i] = 0;
    end

    rst_n = 1'b0;
    repeat (3) step();
    chk("reset.busy", 64'(busy_o[0]), 64'(0));
    chk("reset.chunk_idx", 64'(idx_o[3]), 64'(0));
    rst_n = 1'b1;
    step();

    // GAP=2 and GAP=0 transfers side by side; u0 also gets a stray start and key change mid-transfer
    d0 = n_done[0]; d1 = n_done[1];
    start_s[0] = 1'b1; key_s[0] = 32'h1234ABCD;
    start_s[1] = 1'b1; key_s[1] = 32'hFEDCBA98;
    step();
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    for (int r = 1; r <= 24; r++) begin
      if (r > 1) step();
      if (r <= 22 && (r - 1) % 3 == 0) begin
        chk("s1.load_key", 64'(ld_o[0]), 64'(1));
        chk("s1.key_data", 64'(kd_o[0]), 64'(s1_nib[(r-1)/3]));
        chk("s1.chunk_idx", 64'(idx_o[0]), 64'((r-1)/3));
      end
      if (r == 23) chk("s1.done", 64'(done_o[0]), 64'(1));
      if (r == 24) chk("s1.busy_end", 64'(busy_o[0]), 64'(0));
      if (r <= 8) begin
        chk("s2.load_key", 64'(ld_o[1]), 64'(1));
        chk("s2.key_data", 64'(kd_o[1]), 64'(s2_nib[r-1]));
      end
      if (r == 9) chk("s2.done", 64'(done_o[1]), 64'(1));
      if (r == 5) begin start_s[0] = 1'b1; key_s[0] = '0; end
      if (r == 6) start_s[0] = 1'b0;
    end
    chk("s3.one_done", 64'(n_done[0] - d0), 64'(1));
    chk("s2.one_done", 64'(n_done[1] - d1), 64'(1));

    // abort mid-gap, then a fresh transfer
    start_s[0] = 1'b1; key_s[0] = 32'h1234ABCD;
    step();
    start_s[0] = 1'b0;
    d0 = n_done[0];
    for (int r = 1; r <= 12; r++) begin
      if (r > 1) step();
      if (r == 8) abort_s[0] = 1'b1;
      if (r == 9) begin
        abort_s[0] = 1'b0;
        chk("s4.load_key", 64'(ld_o[0]), 64'(0));
        chk("s4.busy", 64'(busy_o[0]), 64'(0));
        chk("s4.chunk_idx_hold", 64'(idx_o[0]), 64'(2));
      end
      if (r == 12) begin start_s[0] = 1'b1; key_s[0] = 32'hC0FFEE42; end
    end
    step();
    start_s[0] = 1'b0;
    wait_idle("s4.restart_idle");
    chk("s4.restart_done", 64'(n_done[0] - d0), 64'(1));

    // start and abort together never launch
    for (int i = 0; i < NI; i++) begin start_s[i] = 1'b1; abort_s[i] = 1'b1; key_s[i] = 32'hA5A5A5A5; end
    step();
    for (int i = 0; i < NI; i++) begin start_s[i] = 1'b0; abort_s[i] = 1'b0; end
    chk("s5.start_abort_busy", 64'(busy_o[2]), 64'(0));
    step();
    chk("s5.start_abort_load", 64'(ld_o[1]), 64'(0));

    // reset in the middle of a transfer
    d0 = n_done[0];
    start_s[0] = 1'b1; key_s[0] = 32'h1234ABCD;
    step();
    start_s[0] = 1'b0;
    for (int r = 1; r <= 11; r++) begin
      if (r > 1) step();
      if (r == 10) rst_n = 1'b0;
      if (r == 11) begin
        chk("s5.rst_busy", 64'(busy_o[0]), 64'(0));
        chk("s5.rst_chunk_idx", 64'(idx_o[0]), 64'(0));
        rst_n = 1'b1;
      end
    end
    repeat (25) step();
    chk("s5.rst_no_done", 64'(n_done[0] - d0), 64'(0));

    // random loopback on GAP 0, 1, 3
    for (int i = 0; i < NI; i++) dd[i] = n_done[i];
    for (int t = 0; t < 100; t++) begin
      for (int i = 1; i < NI; i++) begin start_s[i] = 1'b1; key_s[i] = $urandom; end
      step();
      for (int i = 1; i < NI; i++) begin start_s[i] = 1'b0; key_s[i] = $urandom; end
      wait_idle("s6.idle");
      repeat ($urandom_range(0, 2)) step();
    end
    for (int i = 1; i < NI; i++) chk($sformatf("s6.u%0d.done_count", i), 64'(n_done[i] - dd[i]), 64'(100));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
